// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with source select, conditional
// branch update, target alignment check and a small exception-entry FSM
// (RUN -> CAPTURE -> VECTOR -> RUN) that captures EPC/cause and vectors the PC.
module pc_sequencer #(
  parameter int unsigned            WIDTH      = 32,
  parameter int unsigned            NUM_SRC    = 4,
  parameter int unsigned            SEL_W      = 2,
  parameter logic [WIDTH-1:0]       RESET_ADDR = '0,
  parameter logic [WIDTH-1:0]       EXC_VECTOR = 32'h0000_0080
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_true,
  input  logic [SEL_W-1:0]         pc_src,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     exc_req,
  input  logic [1:0]               exc_cause_in,
  input  logic                     eret,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         epc,
  output logic [1:0]               cause,
  output logic                     exc_busy,
  output logic                     exc_ack
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_CAPTURE = 2'd1,
    S_VECTOR  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [1:0]       r_cause;
  logic [1:0]       r_pend_cause;

  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_epc_nxt;
  logic [1:0]       w_cause_nxt;
  logic [1:0]       w_pend_nxt;
  logic [WIDTH-1:0] w_tgt;
  logic             w_sel_ok;
  logic             w_upd;
  logic             w_misalign;

  // Source mux; selects at or beyond NUM_SRC leave w_sel_ok low so the update is dropped.
  always_comb begin
    w_tgt    = '0;
    w_sel_ok = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pc_src == SEL_W'(i)) begin
        w_tgt    = src_data[i*WIDTH +: WIDTH];
        w_sel_ok = 1'b1;
      end
    end
  end

  assign w_upd      = pc_write | (pc_write_cond & cond_true);
  assign w_misalign = w_upd & w_sel_ok & (w_tgt[1:0] != 2'b00);

  // Next-state and next-register values; RUN priority is exc_req > misaligned > eret > upd.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_cause_nxt = r_cause;
    w_pend_nxt  = r_pend_cause;
    case (r_state)
      S_RUN: begin
        if (exc_req) begin
          w_state_nxt = S_CAPTURE;
          w_pend_nxt  = exc_cause_in;
        end else if (w_misalign) begin
          w_state_nxt = S_CAPTURE;
          w_pend_nxt  = 2'b11;
        end else if (eret) begin
          w_pc_nxt = r_epc;
        end else if (w_upd && w_sel_ok) begin
          w_pc_nxt = w_tgt;
        end
      end
      S_CAPTURE: begin
        w_epc_nxt   = r_pc;
        w_cause_nxt = r_pend_cause;
        w_state_nxt = S_VECTOR;
      end
      S_VECTOR: begin
        w_pc_nxt    = EXC_VECTOR;
        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // State register; synchronous reset returns to RUN from any state.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // PC, EPC, cause and pending-cause registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_ADDR;
      r_epc        <= '0;
      r_cause      <= '0;
      r_pend_cause <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_epc        <= w_epc_nxt;
      r_cause      <= w_cause_nxt;
      r_pend_cause <= w_pend_nxt;
    end
  end

  assign pc       = r_pc;
  assign epc      = r_epc;
  assign cause    = r_cause;
  assign exc_busy = (r_state != S_RUN);
  // Ack is masked by reset so an aborted vector cycle never reports entry.
  assign exc_ack  = (r_state == S_VECTOR) && !reset;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan steps followed by random stimulus,
// all checked against a behavioural model of the PC/exception rules.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: NUM_SRC = 4
  logic        reset, pc_write, pc_write_cond, cond_true, exc_req, eret;
  logic [1:0]  pc_src, exc_cause_in;
  logic [31:0] src [4];
  logic [127:0] src_data;
  logic [31:0] pc, epc;
  logic [1:0]  cause;
  logic        exc_busy, exc_ack;
  assign src_data = {src[3], src[2], src[1], src[0]};

  // DUT B: NUM_SRC = 3 (out-of-range select)
  logic        b_reset, b_pc_write;
  logic [1:0]  b_pc_src;
  logic [31:0] b_src [3];
  logic [95:0] b_src_data;
  logic [31:0] b_pc, b_epc;
  logic [1:0]  b_cause;
  logic        b_busy, b_ack;
  assign b_src_data = {b_src[2], b_src[1], b_src[0]};

  pc_sequencer #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2),
                 .RESET_ADDR(32'h0000_0000), .EXC_VECTOR(32'h0000_0080)) u_dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .cond_true(cond_true), .pc_src(pc_src), .src_data(src_data), .exc_req(exc_req),
    .exc_cause_in(exc_cause_in), .eret(eret), .pc(pc), .epc(epc), .cause(cause),
    .exc_busy(exc_busy), .exc_ack(exc_ack));

  pc_sequencer #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2),
                 .RESET_ADDR(32'h0000_0000), .EXC_VECTOR(32'h0000_0080)) u_dut_b (
    .clk(clk), .reset(b_reset), .pc_write(b_pc_write), .pc_write_cond(1'b0),
    .cond_true(1'b0), .pc_src(b_pc_src), .src_data(b_src_data), .exc_req(1'b0),
    .exc_cause_in(2'b00), .eret(1'b0), .pc(b_pc), .epc(b_epc), .cause(b_cause),
    .exc_busy(b_busy), .exc_ack(b_ack));

  int n_checks = 0;
  int n_errors = 0;
  int ack_seen = 0;

  // Behavioural model: m_left = edges remaining until the vector is loaded.
  logic [31:0] m_pc = 32'h0, m_epc = 32'h0;
  logic [1:0]  m_cause = 2'b0, m_pend = 2'b0;
  int          m_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Apply the rules for one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic        upd, valid;
    logic [31:0] tgt;
    if (reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'b0; m_pend = 2'b0; m_left = 0;
    end else if (m_left == 2) begin
      m_epc = m_pc; m_cause = m_pend; m_left = 1;
    end else if (m_left == 1) begin
      m_pc = 32'h80; m_left = 0;
    end else begin
      upd   = pc_write || (pc_write_cond && cond_true);
      valid = (int'(pc_src) < 4);
      tgt   = valid ? src[pc_src] : 32'h0;
      if (exc_req) begin
        m_pend = exc_cause_in; m_left = 2;
      end else if (upd && valid && (tgt % 4 != 0)) begin
        m_pend = 2'b11; m_left = 2;
      end else if (eret) begin
        m_pc = m_epc;
      end else if (upd && valid) begin
        m_pc = tgt;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (exc_ack === 1'b1) ack_seen++;
    chk("pc", pc, m_pc);
    chk("epc", epc, m_epc);
    chk("cause", 32'(cause), 32'(m_cause));
    chk("exc_busy", 32'(exc_busy), 32'(m_left != 0));
    chk("exc_ack", 32'(exc_ack), 32'((m_left == 1) && !reset));
  endtask

  task automatic idle_inputs();
    pc_write = 0; pc_write_cond = 0; cond_true = 0; exc_req = 0; eret = 0;
    exc_cause_in = 2'b00; pc_src = 2'd0;
  endtask

  initial begin
    idle_inputs();
    src[0] = 32'h10; src[1] = 32'h0; src[2] = 32'h0; src[3] = 32'h0;
    b_src[0] = 32'h40; b_src[1] = 32'h44; b_src[2] = 32'h48;
    b_pc_write = 0; b_pc_src = 2'd0; b_reset = 1;

    // Reset for two cycles with a pending write
    reset = 1; pc_write = 1;
    step(); chk("rst_pc", pc, 32'h0);
    step(); chk("rst_busy", 32'(exc_busy), 32'h0);
    reset = 0; pc_write = 0;
    step(); chk("post_rst_pc", pc, 32'h0);

    // Source selection and conditional write
    src[0] = 32'h100; src[1] = 32'h200; src[2] = 32'h300; src[3] = 32'h400;
    pc_write = 1; pc_src = 2'd2;
    step(); chk("sel2", pc, 32'h300);
    pc_write = 0; pc_write_cond = 1; cond_true = 0;
    step(); chk("cond_false", pc, 32'h300);
    cond_true = 1; pc_src = 2'd1;
    step(); chk("cond_true", pc, 32'h200);
    idle_inputs();

    // Misaligned target
    ack_seen = 0;
    src[0] = 32'h102; pc_write = 1; pc_src = 2'd0;
    step(); chk("mis_hold", pc, 32'h200); chk("mis_busy", 32'(exc_busy), 32'h1);
    pc_write = 0;
    step(); chk("mis_epc", epc, 32'h200); chk("mis_cause", 32'(cause), 32'h3);
    step(); chk("mis_vec", pc, 32'h80);
    step(); chk("mis_ack_once", 32'(ack_seen), 32'h1);

    // External exception with simultaneous write, then eret
    src[0] = 32'h100; pc_write = 1; pc_src = 2'd3;
    step(); chk("to_400", pc, 32'h400);
    exc_req = 1; exc_cause_in = 2'b01; pc_src = 2'd0;
    step(); chk("ext_hold", pc, 32'h400);
    // Busy masking: everything asserted during CAPTURE
    src[0] = 32'h500; pc_write = 1; eret = 1; exc_req = 1; exc_cause_in = 2'b10;
    step(); chk("ext_epc", epc, 32'h400); chk("ext_cause", 32'(cause), 32'h1);
    idle_inputs();
    step(); chk("ext_vec", pc, 32'h80); chk("ext_busy_low", 32'(exc_busy), 32'h0);
    step(); chk("no_second_exc", 32'(exc_busy), 32'h0);
    eret = 1;
    step(); chk("eret", pc, 32'h400);
    eret = 0;

    // Reset during VECTOR
    exc_req = 1; exc_cause_in = 2'b10;
    step(); exc_req = 0;
    step(); chk("vec_ack", 32'(exc_ack), 32'h1);
    reset = 1; #1;
    chk("rst_masks_ack", 32'(exc_ack), 32'h0);
    step(); chk("vec_rst_pc", pc, 32'h0); chk("vec_rst_busy", 32'(exc_busy), 32'h0);
    reset = 0;
    step();

    // Random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 63) == 0);
      pc_write      = $urandom_range(0, 1);
      pc_write_cond = $urandom_range(0, 1);
      cond_true     = $urandom_range(0, 1);
      exc_req       = ($urandom_range(0, 9) == 0);
      exc_cause_in  = 2'($urandom_range(0, 3));
      eret          = ($urandom_range(0, 7) == 0);
      pc_src        = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        src[k] = $urandom;
        if ($urandom_range(0, 3) != 0) src[k][1:0] = 2'b00;
      end
      step();
    end
    idle_inputs(); reset = 0;
    step();

    // DUT B: out-of-range select holds pc without an exception
    b_reset = 0; b_pc_write = 1; b_pc_src = 2'd0;
    @(posedge clk); #1; chk("b_load", b_pc, 32'h40);
    b_pc_src = 2'd3; b_src[0] = 32'h103;
    @(posedge clk); #1; chk("b_oor_hold", b_pc, 32'h40); chk("b_oor_busy", 32'(b_busy), 32'h0);
    @(posedge clk); #1; chk("b_oor_hold2", b_pc, 32'h40); chk("b_oor_busy2", 32'(b_busy), 32'h0);
    chk("b_oor_cause", 32'(b_cause), 32'h0); chk("b_oor_epc", b_epc, 32'h0);
    chk("b_oor_ack", 32'(b_ack), 32'h0);
    b_pc_write = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered program-counter unit that replaces the combinational PC-source multiplexer in the multicycle datapath. It selects the next PC from NUM_SRC flattened sources, supports unconditional and conditional (branch) writes, and checks target alignment. It also runs a small exception-entry FSM that captures EPC and cause and vectors the PC. The control unit drives it and the instruction-fetch path consumes its PC output.

Parameters:
WIDTH, 32, PC/data width in bits.
NUM_SRC, 4, number of next-PC sources (minimum 2).
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_SRC.
RESET_ADDR, 32'h0000_0000, PC value after reset.
EXC_VECTOR, 32'h0000_0080, PC loaded on exception entry.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
pc_write  in  1  unconditional PC update request.
pc_write_cond  in  1  conditional PC update request, effective only when cond_true=1.
cond_true  in  1  branch condition from ALU.
pc_src  in  SEL_W  source select; source i = src_data[i*WIDTH +: WIDTH].
src_data  in  NUM_SRC*WIDTH  flattened next-PC candidates.
exc_req  in  1  external exception request (level, sampled each cycle).
exc_cause_in  in  2  cause code accompanying exc_req.
eret  in  1  return from exception: PC <= EPC.
pc  out  WIDTH  current PC register.
epc  out  WIDTH  exception PC register.
cause  out  2  latched cause register.
exc_busy  out  1  high while FSM is not in RUN.
exc_ack  out  1  one-cycle pulse when PC is loaded with EXC_VECTOR.

Behaviour:
- Reset (synchronous, highest priority): pc=RESET_ADDR, epc=0, cause=0, exc_busy=0, exc_ack=0, FSM=RUN. Reset asserted in any FSM state aborts exception entry in that cycle.
- Update enable: upd = pc_write | (pc_write_cond & cond_true).
- Target: tgt = source[pc_src].
- pc_src >= NUM_SRC: the update is suppressed (pc holds) and no exception is raised.
- Misaligned target: when upd=1, pc_src is valid and tgt[1:0]!=0, the update is suppressed and the block raises an internal exception with cause 2'b11.
- FSM states and transitions:
  - RUN:
    - exc_req=1 or misaligned fires: go to CAPTURE.
    - Else eret=1: pc <= epc and stay in RUN.
    - Else upd with valid, aligned target: pc <= tgt and stay in RUN.
    - Priority within RUN: exc_req > misaligned > eret > upd. An external exc_req in the same cycle as a misaligned update records exc_cause_in, not 2'b11.
  - CAPTURE (1 cycle): epc <= pc (the PC is unchanged since entry), cause <= the recorded code, go to VECTOR.
  - VECTOR (1 cycle): pc <= EXC_VECTOR, exc_ack=1 for this cycle only, go to RUN.
- exc_busy = (state != RUN), combinational from the state register.
- While exc_busy=1, all of pc_write, pc_write_cond, eret and exc_req are ignored; they are not queued.
- Exception latency: exc_req sampled at edge N -> epc and cause valid after edge N+1 -> pc=EXC_VECTOR after edge N+2.
- Normal PC update takes effect at the next rising edge. pc, epc and cause are all registered outputs.
- pc is never written by any path other than those listed. No wrap logic is needed; targets are taken verbatim at WIDTH bits.

Test Plan:
- Reset: assert reset for 2 cycles with pc_write=1 and src0=32'h10 -> pc=0, epc=0, cause=0, exc_busy=0 throughout and after release.
- Source selection: pc_write=1, src0..3 = 32'h100/200/300/400, pc_src=2 -> pc=32'h300 after one edge. Then pc_write_cond=1, cond_true=0 -> pc holds 32'h300. Then cond_true=1, pc_src=1 -> pc=32'h200.
- Misaligned: with pc=32'h200, pc_write=1, pc_src=0, src0=32'h102 -> pc stays 32'h200. Next edge: epc=32'h200, cause=2'b11. Following edge: pc=32'h80 and exc_ack pulses exactly one cycle.
- External exception and return: at pc=32'h400, exc_req=1, exc_cause_in=2'b01, with pc_write=1 in the same cycle -> sequence CAPTURE, VECTOR; epc=32'h400, cause=01, pc=32'h80. Then eret=1 -> pc=32'h400.
- Busy masking: during CAPTURE drive pc_write=1 (src=32'h500), eret=1 and exc_req=1 -> ignored; pc reaches 32'h80, exc_busy drops, and no second exception occurs.
- Out-of-range select and mid-exception reset: NUM_SRC=3, pc_src=3, pc_write=1 -> pc holds and no exception. Then assert reset during VECTOR -> pc=RESET_ADDR, exc_ack=0, FSM=RUN.
